// File: rtl/cavlc_pkg.sv
// Shared constants for the CAVLC bitstream front end.
// Sizes of the bit buffer, input word and lookahead window.
package cavlc_pkg;

    localparam int BUF_W  = 64;
    localparam int WORD_W = 32;
    localparam int WIN_W  = 16;
    localparam int CNT_W  = 7;
    localparam int SH_W   = 5;

endpackage

// File: rtl/bit_funnel.sv
// Shift-and-merge datapath for the bitstream buffer.
// Consumes bits from the top, then appends a word below the remainder.
module bit_funnel
    import cavlc_pkg::*;
(
    input  logic [BUF_W-1:0]  buf_in,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              shift_en,
    input  logic [SH_W-1:0]   num_shift,
    input  logic              load,
    input  logic [WORD_W-1:0] in_data,
    output logic [BUF_W-1:0]  buf_out,
    output logic [CNT_W-1:0]  count_out
);

    logic [BUF_W-1:0] shifted;
    logic [CNT_W-1:0] cnt_s;
    logic [BUF_W-1:0] word_top;

    assign word_top = {in_data, {(BUF_W - WORD_W){1'b0}}};

    // Shift first, then merge the incoming word just below the survivors.
    always_comb begin
        shifted   = buf_in;
        cnt_s     = count_in;
        if (shift_en) begin
            shifted = buf_in << num_shift;
            cnt_s   = count_in - CNT_W'(num_shift);
        end
        buf_out   = shifted;
        count_out = cnt_s;
        if (load) begin
            buf_out   = shifted | (word_top >> cnt_s);
            count_out = cnt_s + CNT_W'(WORD_W);
        end
    end

endmodule

// File: rtl/bitstream_buffer.sv
// 64-bit MSB-aligned bitstream buffer with a 16-bit lookahead window.
// Holds state, position counter and the sticky error flag.
module bitstream_buffer
    import cavlc_pkg::*;
(
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Clear,
    input  logic [31:0] InData,
    input  logic        InValid,
    output logic        InReady,
    input  logic        ShiftEn,
    input  logic [4:0]  NumShift,
    output logic [15:0] BitstreamShifted,
    output logic        BitsValid,
    output logic [31:0] BitPos,
    output logic        Error
);

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [31:0]      bit_pos_q;
    logic             error_q;
    logic             shift_legal;
    logic             shift_bad;
    logic             load;

    assign shift_legal = ShiftEn
                       && (NumShift <= SH_W'(WIN_W))
                       && (CNT_W'(NumShift) <= count_q);
    assign shift_bad   = ShiftEn && !shift_legal;
    assign InReady     = (count_q <= CNT_W'(WORD_W));
    assign load        = InValid && InReady;

    assign BitstreamShifted = buf_q[BUF_W-1 -: WIN_W];
    assign BitsValid        = (count_q >= CNT_W'(WIN_W));
    assign BitPos           = bit_pos_q;
    assign Error            = error_q;

    bit_funnel u_funnel (
        .buf_in    (buf_q),
        .count_in  (count_q),
        .shift_en  (shift_legal),
        .num_shift (NumShift),
        .load      (load),
        .in_data   (InData),
        .buf_out   (buf_d),
        .count_out (count_d)
    );

    // Buffer state, consumed-bit position and sticky error.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            buf_q     <= '0;
            count_q   <= '0;
            bit_pos_q <= '0;
            error_q   <= 1'b0;
        end else if (Clear) begin
            buf_q     <= '0;
            count_q   <= '0;
            bit_pos_q <= '0;
            error_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            if (shift_legal)
                bit_pos_q <= bit_pos_q + 32'(NumShift);
            if (shift_bad)
                error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bitstream_buffer.sv
// Scoreboard bench for bitstream_buffer.
// Driver pushes expected outputs; a monitor pops and compares.
module tb_bitstream_buffer;

    logic        Clk;
    logic        nReset;
    logic        Clear;
    logic [31:0] InData;
    logic        InValid;
    logic        InReady;
    logic        ShiftEn;
    logic [4:0]  NumShift;
    logic [15:0] BitstreamShifted;
    logic        BitsValid;
    logic [31:0] BitPos;
    logic        Error;

    bitstream_buffer dut (
        .Clk              (Clk),
        .nReset           (nReset),
        .Clear            (Clear),
        .InData           (InData),
        .InValid          (InValid),
        .InReady          (InReady),
        .ShiftEn          (ShiftEn),
        .NumShift         (NumShift),
        .BitstreamShifted (BitstreamShifted),
        .BitsValid        (BitsValid),
        .BitPos           (BitPos),
        .Error            (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [15:0] sh;
        logic        bv;
        logic        ir;
        logic [31:0] bp;
        logic        err;
    } exp_t;

    exp_t q_exp[$];
    int   checks   = 0;
    int   failures = 0;

    bit          mq[$];
    logic [31:0] m_bp;
    logic        m_err;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic exp_t mk(string nm, logic [15:0] sh, logic bv,
                                logic ir, logic [31:0] bp, logic err);
        exp_t e;
        e.name = nm;
        e.sh   = sh;
        e.bv   = bv;
        e.ir   = ir;
        e.bp   = bp;
        e.err  = err;
        return e;
    endfunction

    function automatic exp_t model_exp(string nm);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++)
            if (i < mq.size())
                w[15-i] = mq[i];
        return mk(nm, w, mq.size() >= 16, mq.size() <= 32, m_bp, m_err);
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_bp  = '0;
        m_err = 1'b0;
    endfunction

    function automatic void model_step(logic clr, logic iv, logic [31:0] d,
                                       logic se, logic [4:0] ns);
        bit rdy;
        if (clr) begin
            model_clear();
            return;
        end
        rdy = (mq.size() <= 32);
        if (se) begin
            if (ns <= 16 && int'(ns) <= mq.size()) begin
                for (int i = 0; i < int'(ns); i++)
                    void'(mq.pop_front());
                m_bp = m_bp + 32'(ns);
            end else begin
                m_err = 1'b1;
            end
        end
        if (iv && rdy)
            for (int i = 31; i >= 0; i--)
                mq.push_back(d[i]);
    endfunction

    task automatic step(input logic clr, input logic iv,
                        input logic [31:0] d, input logic se,
                        input logic [4:0] ns, input bit hand,
                        input exp_t e);
        Clear    = clr;
        InValid  = iv;
        InData   = d;
        ShiftEn  = se;
        NumShift = ns;
        model_step(clr, iv, d, se, ns);
        @(posedge Clk);
        #1;
        Clear   = 1'b0;
        InValid = 1'b0;
        ShiftEn = 1'b0;
        if (hand)
            q_exp.push_back(e);
        else
            q_exp.push_back(model_exp("rnd"));
    endtask

    // Monitor: compare every pending expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk({e.name, ".sh"},  32'(BitstreamShifted), 32'(e.sh));
                chk({e.name, ".bv"},  32'(BitsValid),        32'(e.bv));
                chk({e.name, ".ir"},  32'(InReady),          32'(e.ir));
                chk({e.name, ".bp"},  BitPos,                e.bp);
                chk({e.name, ".err"}, 32'(Error),            32'(e.err));
            end
        end
    end

    exp_t z;
    int   sent;
    int   cyc;
    bit   acc;

    initial begin
        z = mk("none", 16'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        nReset   = 1'b0;
        Clear    = 1'b0;
        InData   = '0;
        InValid  = 1'b0;
        ShiftEn  = 1'b0;
        NumShift = '0;
        model_clear();
        #12;
        q_exp.push_back(mk("reset", 16'h0, 1'b0, 1'b1, 32'h0, 1'b0));
        @(negedge Clk);
        #2;
        nReset = 1'b1;
        @(posedge Clk);
        #1;

        step(0, 1, 32'hA5A5_0F0F, 0, 0, 1,
             mk("ld1", 16'hA5A5, 1, 1, 0, 0));

        step(1, 0, 0, 0, 0, 1, mk("clr1", 0, 0, 1, 0, 0));
        step(0, 1, 32'h1234_5678, 0, 0, 1,
             mk("ldA", 16'h1234, 1, 1, 0, 0));
        step(0, 1, 32'h9ABC_DEF0, 0, 0, 1,
             mk("ldB", 16'h1234, 1, 0, 0, 0));
        step(0, 1, 32'hDEAD_BEEF, 1, 4, 1,
             mk("full_sh4", 16'h2345, 1, 0, 4, 0));
        step(0, 0, 0, 1, 16, 1, mk("sh16a", 16'h6789, 1, 0, 20, 0));
        step(0, 0, 0, 1, 16, 1, mk("sh16b", 16'hABCD, 1, 1, 36, 0));
        step(0, 0, 0, 1, 16, 1, mk("tail", 16'hEF00, 0, 1, 52, 0));

        step(1, 0, 0, 0, 0, 1, mk("clr2", 0, 0, 1, 0, 0));
        step(0, 1, 32'h1234_5678, 0, 0, 1,
             mk("ldC", 16'h1234, 1, 1, 0, 0));
        step(0, 0, 0, 1, 12, 1, mk("sh12", 16'h4567, 1, 1, 12, 0));
        step(0, 1, 32'hFFFF_0000, 1, 12, 1,
             mk("sh_ld", 16'h78FF, 1, 0, 24, 0));

        step(1, 0, 0, 0, 0, 1, mk("clr3", 0, 0, 1, 0, 0));
        step(0, 1, 32'hAABB_CCDD, 0, 0, 1,
             mk("ldD", 16'hAABB, 1, 1, 0, 0));
        step(0, 0, 0, 1, 16, 1, mk("sh16c", 16'hCCDD, 1, 1, 16, 0));
        step(0, 0, 0, 1, 8, 1, mk("sh8", 16'hDD00, 0, 1, 24, 0));
        step(0, 0, 0, 1, 9, 1, mk("under", 16'hDD00, 0, 1, 24, 1));
        step(0, 0, 0, 1, 0, 1, mk("noop0", 16'hDD00, 0, 1, 24, 1));
        step(0, 1, 32'h1122_3344, 1, 9, 1,
             mk("bad_ld", 16'hDD11, 1, 0, 24, 1));
        step(0, 0, 0, 1, 20, 1, mk("gt16", 16'hDD11, 1, 0, 24, 1));
        step(1, 0, 0, 0, 0, 1, mk("clr4", 0, 0, 1, 0, 0));
        step(0, 1, 32'h8000_0001, 1, 0, 1,
             mk("noop_ld", 16'h8000, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 1, mk("clr5", 0, 0, 1, 0, 0));

        sent = 0;
        cyc  = 0;
        while (sent < 100 && cyc < 3000) begin
            acc = ($urandom_range(0, 3) != 0) && (mq.size() <= 32);
            step(0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
                 5'($urandom_range(0, 16)), 0, z);
            if (acc && !Clear)
                sent = sent + 0;
            cyc++;
            if (m_bp + 32'(mq.size()) >= 32'(32 * (sent + 1)))
                sent++;
        end
        chk("rnd_budget", 32'(sent), 32'd100);

        step(1, 0, 0, 0, 0, 0, z);
        step(0, 1, 32'h0123_4567, 0, 0, 0, z);
        step(0, 0, 0, 1, 8, 0, z);
        step(0, 1, 32'h89AB_CDEF, 0, 0, 0, z);
        step(0, 0, 0, 1, 16, 1, mk("c40", 16'h6789, 1, 0, 24, 0));
        @(negedge Clk);
        #2;
        nReset = 1'b0;
        #1;
        chk("areset.sh", 32'(BitstreamShifted), 32'h0);
        chk("areset.bv", 32'(BitsValid), 32'h0);
        chk("areset.ir", 32'(InReady), 32'h1);
        chk("areset.bp", BitPos, 32'h0);
        model_clear();
        @(posedge Clk);
        #2;
        nReset = 1'b1;
        step(0, 1, 32'hCAFE_F00D, 0, 0, 1,
             mk("post_rst", 16'hCAFE, 1, 1, 0, 0));

        repeat (2) @(negedge Clk);
        #1;
        chk("drain", 32'(q_exp.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitstream_buffer.md
BITSTREAM_BUFFER -- requirements
Module: bitstream_buffer

Interface
REQ-001 SHALL have port Clk, input, 1, rising-edge clock.
REQ-002 SHALL have port nReset, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port Clear, input, 1, synchronous flush at the start of a new block or slice.
REQ-004 SHALL have port InData, input, 32, next bitstream word, MSB first.
REQ-005 SHALL have port InValid, input, 1, InData valid.
REQ-006 SHALL have port InReady, output, 1, buffer accepts InData this cycle.
REQ-007 SHALL have port ShiftEn, input, 1, consume NumShift bits this cycle.
REQ-008 SHALL have port NumShift, input, 5, bits to consume (0..16).
REQ-009 SHALL have port BitstreamShifted, output, 16, next 16 unconsumed bits, MSB-aligned.
REQ-010 SHALL have port BitsValid, output, 1, at least 16 unconsumed bits held.
REQ-011 SHALL have port BitPos, output, 32, total bits consumed since the last Clear or reset.
REQ-012 SHALL have port Error, output, 1, sticky underflow or illegal-shift flag.

Function
REQ-013 SHALL hold a 64-bit register Buf with unconsumed bits MSB-aligned; Count (0..64, 7 bits) is the number of valid bits; bits below the valid region SHALL be zero.
REQ-014 SHALL drive BitstreamShifted = Buf[63:48] directly from the register; a shift or load at edge N is visible after edge N.
REQ-015 SHALL drive BitsValid = (Count >= 16), combinationally from Count.
REQ-016 SHALL drive InReady = (Count <= 32) from the current Count, independent of ShiftEn.
REQ-017 A shift is legal when ShiftEn=1, NumShift <= 16 and NumShift <= Count; a legal shift SHALL set Buf <= Buf << NumShift, Count -= NumShift, BitPos += NumShift (32-bit wrap).
REQ-018 A load occurs when InValid && InReady; the word SHALL be placed immediately below the remaining bits: Buf |= InData << (32 - Count'), where Count' is Count after any same-cycle shift, and Count' += 32.
REQ-019 A legal shift and a load in the same cycle SHALL both take effect on that edge, with the shift applied first.
REQ-020 ShiftEn with NumShift = 0 SHALL be a legal no-op.
REQ-021 An illegal shift (NumShift > Count, or NumShift > 16) SHALL leave Buf, Count and BitPos unchanged and set Error; a same-cycle load SHALL still proceed.
REQ-022 Error SHALL stay set until Clear or reset.
REQ-023 Clear SHALL set Buf=0, Count=0, BitPos=0, Error=0 on the next edge; it has priority over shift and load, and InData is dropped in that cycle.
REQ-024 Count SHALL never exceed 64; by construction a load only occurs when Count' <= 32.

Reset
REQ-025 nReset low SHALL asynchronously set Buf=0, Count=0, BitPos=0, Error=0, giving BitstreamShifted=0, BitsValid=0, InReady=1.
REQ-026 Reset asserted mid-stream SHALL discard all buffered bits; after release the block behaves as freshly cleared.

Structure
REQ-027 Constants BUF_W=64, WORD_W=32 and WIN_W=16 SHALL live in shared package cavlc_pkg.
REQ-028 The combinational shift-and-merge datapath (Buf, Count, NumShift, InData -> next Buf) SHALL be one sub-module, bit_funnel; the state register, control and counters remain in bitstream_buffer.

Verification
REQ-029 Reset, then load 0xA5A5_0F0F -> next cycle BitstreamShifted=0xA5A5, BitsValid=1, Count=32, InReady=1.
REQ-030 Load 0x1234_5678 and 0x9ABC_DEF0, then shift 4 -> BitstreamShifted=0x2345, Count=60, InReady=0; a third InValid is not accepted.
REQ-031 With Count=20, shift 12 and load 0xFFFF_0000 in the same cycle -> Count=40; BitstreamShifted = remaining 8 bits followed by 0xFF.
REQ-032 With Count=8, ShiftEn with NumShift=9 -> Error=1, Count stays 8, BitPos unchanged; a later Clear -> Error=0, Count=0, BitPos=0.
REQ-033 Stream 100 random words while consuming random shift sizes 0..16 -> BitstreamShifted matches a reference bit-queue model every cycle; BitPos equals the sum of legal shifts.
REQ-034 Assert nReset mid-stream with Count=40 -> outputs go to reset values immediately, without waiting for a clock edge.
